// File: rtl/ac97_codec_responder.sv
// ac97_codec_responder: codec end of the AC-link; generates BIT_CLK, decodes controller
// frames into a 64-entry register file and PCM outputs, and returns slots 0-4 on SDATA_IN.
module ac97_codec_responder #(
    parameter int BITCLK_DIV   = 4,
    parameter int READY_FRAMES = 4
) (
    input  logic        clk_i,
    input  logic        RESET,
    output logic        BIT_CLK,
    input  logic        SYNC,
    input  logic        SDATA_OUT,
    output logic        SDATA_IN,
    input  logic [19:0] adc_left,
    input  logic [19:0] adc_right,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right,
    output logic        pcm_valid,
    output logic        reg_wr,
    output logic [6:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        codec_ready,
    output logic        frame_err
);
    localparam int DW = (BITCLK_DIV > 1) ? $clog2(BITCLK_DIV) : 1;
    localparam int RW = $clog2(READY_FRAMES + 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic [1:0]    sync_s_q, sdo_s_q;
    logic          sync_last_q, sync_last_d;
    logic [7:0]    idx_q, idx_d, smp_idx_q, smp_idx_d;
    logic          tx_en_q, tx_en_d;
    logic [254:0]  rx_q, rx_d;
    logic [255:0]  txsr_q, txsr_d;
    logic          sdi_q, sdi_d;
    logic          resp_q, resp_d;
    logic [6:0]    resp_addr_q, resp_addr_d;
    logic [RW-1:0] rdy_cnt_q, rdy_cnt_d;
    logic          ready_q, ready_d;
    logic [19:0]   pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
    logic          pcm_v_q, pcm_v_d, wr_q, wr_d, ferr_q, ferr_d;
    logic [6:0]    wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic [15:0]   regs_q [64];

    logic          tc, rise, fall, sync_rise, aligned, misalign, frame_end;
    logic          is_cmd, do_wr, do_rd, do_pcm, load;
    logic [255:0]  frame, tx_frame;
    logic [6:0]    addr;

    function automatic logic [15:0] rst_val(input logic [5:0] e);
        return (e == 6'h00) ? 16'h0D50 :
               (e == 6'h13) ? 16'h000F :
               (e == 6'h3E) ? 16'h4E53 :
               (e == 6'h3F) ? 16'h4350 : 16'h0000;
    endfunction

    assign tc        = (div_q == DW'(BITCLK_DIV - 1));
    assign rise      = tc & ~bclk_q;
    assign fall      = tc & bclk_q;
    assign sync_rise = sync_s_q[1] & ~sync_last_q;
    assign aligned   = (state_q == LOCK);
    // Index 0 as the next expected sample means the previous frame ended cleanly at 255.
    assign misalign  = fall & sync_rise & aligned & (idx_q != 8'd0);
    assign frame_end = fall & aligned & ~sync_rise & (idx_q == 8'd255);
    assign frame     = {rx_q, sdo_s_q[1]};

    assign addr   = frame[238:232];
    assign is_cmd = frame[255] & frame[254] & ~addr[0];
    assign do_wr  = frame_end & is_cmd & ~frame[239] & frame[253] &
                    (addr != 7'h00) & (addr != 7'h7C) & (addr != 7'h7E);
    assign do_rd  = frame_end & is_cmd & frame[239];
    assign do_pcm = frame_end & frame[255] & frame[252] & frame[251];
    assign load   = rise & tx_en_q & (smp_idx_q == 8'd0);

    assign tx_frame = ready_q ? {ready_q, resp_q, resp_q, ready_q, ready_q, 11'b0,
                                 resp_q ? {1'b0, resp_addr_q, 12'b0} : 20'b0,
                                 resp_q ? {regs_q[resp_addr_q[6:1]], 4'b0} : 20'b0,
                                 adc_left, adc_right, 160'b0} : 256'b0;

    always_comb begin
        state_d     = (fall & sync_rise) ? LOCK : state_q;
        div_d       = tc ? '0 : div_q + 1'b1;
        bclk_d      = tc ? ~bclk_q : bclk_q;
        sync_last_d = fall ? sync_s_q[1] : sync_last_q;
        idx_d       = fall ? (sync_rise ? 8'd1 : idx_q + 8'd1) : idx_q;
        smp_idx_d   = fall ? (sync_rise ? 8'd0 : idx_q) : smp_idx_q;
        tx_en_d     = fall ? (state_d == LOCK) : tx_en_q;
        rx_d        = fall ? frame[254:0] : rx_q;
        txsr_d      = load ? {tx_frame[254:0], 1'b0} : (rise ? {txsr_q[254:0], 1'b0} : txsr_q);
        sdi_d       = rise ? (load ? tx_frame[255] : tx_en_q & txsr_q[255]) : sdi_q;
        resp_d      = do_rd | (resp_q & ~load);
        resp_addr_d = do_rd ? addr : resp_addr_q;
        rdy_cnt_d   = (frame_end & ~ready_q) ? rdy_cnt_q + 1'b1 : rdy_cnt_q;
        ready_d     = ready_q | (frame_end & (rdy_cnt_q == RW'(READY_FRAMES - 1)));
        pcm_l_d     = do_pcm ? frame[199:180] : pcm_l_q;
        pcm_r_d     = do_pcm ? frame[179:160] : pcm_r_q;
        pcm_v_d     = do_pcm;
        wr_d        = do_wr;
        wr_addr_d   = do_wr ? addr : wr_addr_q;
        wr_data_d   = do_wr ? frame[219:204] : wr_data_q;
        ferr_d      = misalign;
    end

    always_ff @(posedge clk_i) begin
        if (RESET) begin
            state_q     <= HUNT;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            sync_s_q    <= 2'b00;
            sdo_s_q     <= 2'b00;
            sync_last_q <= 1'b0;
            idx_q       <= 8'd0;
            smp_idx_q   <= 8'd0;
            tx_en_q     <= 1'b0;
            rx_q        <= '0;
            txsr_q      <= '0;
            sdi_q       <= 1'b0;
            resp_q      <= 1'b0;
            resp_addr_q <= 7'd0;
            rdy_cnt_q   <= '0;
            ready_q     <= 1'b0;
            pcm_l_q     <= 20'd0;
            pcm_r_q     <= 20'd0;
            pcm_v_q     <= 1'b0;
            wr_q        <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 16'd0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            sync_s_q    <= {sync_s_q[0], SYNC};
            sdo_s_q     <= {sdo_s_q[0], SDATA_OUT};
            sync_last_q <= sync_last_d;
            idx_q       <= idx_d;
            smp_idx_q   <= smp_idx_d;
            tx_en_q     <= tx_en_d;
            rx_q        <= rx_d;
            txsr_q      <= txsr_d;
            sdi_q       <= sdi_d;
            resp_q      <= resp_d;
            resp_addr_q <= resp_addr_d;
            rdy_cnt_q   <= rdy_cnt_d;
            ready_q     <= ready_d;
            pcm_l_q     <= pcm_l_d;
            pcm_r_q     <= pcm_r_d;
            pcm_v_q     <= pcm_v_d;
            wr_q        <= wr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ferr_q      <= ferr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (RESET)
            for (int i = 0; i < 64; i++) regs_q[i] <= rst_val(6'(i));
        else if (do_wr)
            regs_q[addr[6:1]] <= frame[219:204];
    end

    assign BIT_CLK     = bclk_q;
    assign SDATA_IN    = sdi_q;
    assign pcm_left    = pcm_l_q;
    assign pcm_right   = pcm_r_q;
    assign pcm_valid   = pcm_v_q;
    assign reg_wr      = wr_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign codec_ready = ready_q;
    assign frame_err   = ferr_q;
endmodule

// File: tb/tb_ac97_codec_responder.sv
// tb_ac97_codec_responder: drives AC-link frames as the controller would and compares
// strobes, register traffic and returned slots with a frame-level model of the codec.
module tb_ac97_codec_responder;
    logic        clk_i = 1'b0, RESET = 1'b1, SYNC = 1'b0, SDATA_OUT = 1'b0;
    logic [19:0] adc_left = 20'd0, adc_right = 20'd0;
    logic        BIT_CLK, SDATA_IN, pcm_valid, reg_wr, codec_ready, frame_err;
    logic [19:0] pcm_left, pcm_right;
    logic [6:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;

    always #5 clk_i = ~clk_i;

    ac97_codec_responder #(.BITCLK_DIV(4), .READY_FRAMES(4)) dut (
        .clk_i(clk_i), .RESET(RESET), .BIT_CLK(BIT_CLK), .SYNC(SYNC),
        .SDATA_OUT(SDATA_OUT), .SDATA_IN(SDATA_IN), .adc_left(adc_left),
        .adc_right(adc_right), .pcm_left(pcm_left), .pcm_right(pcm_right),
        .pcm_valid(pcm_valid), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .codec_ready(codec_ready), .frame_err(frame_err)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe log: every cycle a strobe is high adds one entry, so a stretched pulse shows up as extra entries.
    logic [22:0] wr_log [$];
    logic [39:0] pcm_log [$];
    int          ferr_n = 0;
    always @(negedge clk_i) begin
        if (reg_wr) wr_log.push_back({reg_wr_addr, reg_wr_data});
        if (pcm_valid) pcm_log.push_back({pcm_left, pcm_right});
        if (frame_err) ferr_n++;
    end

    logic [15:0]  mreg [128];
    int           mframes;
    bit           mpend;
    logic [6:0]   mpaddr;
    bit           exp_wr, exp_pcm;
    logic [22:0]  exp_wr_v;
    logic [39:0]  exp_pcm_v;
    int           wr_rd = 0, pcm_rd = 0, ferr_exp = 0;
    logic [255:0] cap_prev, t_prev;
    bit           have_prev = 0;

    task automatic model_reset();
        for (int a = 0; a < 128; a++) mreg[a] = 16'h0000;
        mreg[7'h00] = 16'h0D50;
        mreg[7'h26] = 16'h000F;
        mreg[7'h7C] = 16'h4E53;
        mreg[7'h7E] = 16'h4350;
        mframes = 0;
        mpend = 0;
        mpaddr = 7'd0;
    endtask

    task automatic model_load(input logic [19:0] al, input logic [19:0] ar, output logic [255:0] t);
        bit r;
        r = (mframes >= 4);
        t = '0;
        if (r) begin
            t[255:251] = {1'b1, mpend, mpend, 1'b1, 1'b1};
            if (mpend) begin
                t[238:232] = mpaddr;
                t[219:204] = mreg[mpaddr];
            end
            t[199:180] = al;
            t[179:160] = ar;
        end
        mpend = 0;
    endtask

    task automatic model_decode(input logic [255:0] f);
        logic [15:0] tag;
        logic [19:0] s1, s2;
        logic [6:0]  a;
        tag = f[255:240];
        s1 = f[239:220];
        s2 = f[219:200];
        a = s1[18:12];
        mframes++;
        exp_pcm = tag[15] && tag[12] && tag[11];
        exp_pcm_v = f[199:160];
        exp_wr = 0;
        if (tag[15] && tag[14] && !a[0]) begin
            if (s1[19]) begin
                mpend = 1;
                mpaddr = a;
            end else if (tag[13] && a != 7'h00 && a != 7'h7C && a != 7'h7E) begin
                mreg[a] = s2[19:4];
                exp_wr = 1;
                exp_wr_v = {a, s2[19:4]};
            end
        end
    endtask

    function automatic logic [255:0] mk(input logic [15:0] tag, input logic [19:0] s1,
                                        input logic [19:0] s2, input logic [19:0] s3,
                                        input logic [19:0] s4);
        return {tag, s1, s2, s3, s4, 160'b0};
    endfunction

    task automatic send_bits(input logic [255:0] f, input int n, output logic [255:0] cap);
        cap = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge BIT_CLK);
            #1;
            SYNC = (k < 16);
            SDATA_OUT = f[255-k];
            @(negedge BIT_CLK);
            #1;
            cap[255-k] = SDATA_IN;
        end
    endtask

    task automatic check_tx(input logic [255:0] got, input logic [255:0] exp);
        check("tx_slot0", 64'(got[255:240]), 64'(exp[255:240]));
        check("tx_slot1", 64'(got[239:220]), 64'(exp[239:220]));
        check("tx_slot2", 64'(got[219:200]), 64'(exp[219:200]));
        check("tx_slot3", 64'(got[199:180]), 64'(exp[199:180]));
        check("tx_slot4", 64'(got[179:160]), 64'(exp[179:160]));
        check("tx_tail_zero", 64'(|got[159:0]), 64'(|exp[159:0]));
    endtask

    task automatic check_strobes();
        check("reg_wr_count", 64'(wr_log.size() - wr_rd), 64'(exp_wr));
        if (exp_wr && wr_log.size() > wr_rd) check("reg_wr_value", 64'(wr_log[wr_rd]), 64'(exp_wr_v));
        wr_rd = wr_log.size();
        check("pcm_valid_count", 64'(pcm_log.size() - pcm_rd), 64'(exp_pcm));
        if (exp_pcm && pcm_log.size() > pcm_rd) check("pcm_value", 64'(pcm_log[pcm_rd]), 64'(exp_pcm_v));
        pcm_rd = pcm_log.size();
        check("frame_err_count", 64'(ferr_n), 64'(ferr_exp));
        check("codec_ready", 64'(codec_ready), 64'(mframes >= 4));
    endtask

    task automatic run_frame(input logic [255:0] f, input logic [19:0] al, input logic [19:0] ar);
        logic [255:0] t, cap;
        adc_left = al;
        adc_right = ar;
        model_load(al, ar, t);
        send_bits(f, 256, cap);
        if (have_prev) check_tx({cap_prev[254:0], cap[255]}, t_prev);
        cap_prev = cap;
        t_prev = t;
        have_prev = 1;
        model_decode(f);
        repeat (2) @(posedge clk_i);
        #1;
        check_strobes();
    endtask

    task automatic misalign_frame(input logic [255:0] partial, input logic [255:0] f);
        logic [255:0] t, cap;
        model_load(adc_left, adc_right, t);
        send_bits(partial, 100, cap);
        if (have_prev) check_tx({cap_prev[254:0], cap[255]}, t_prev);
        have_prev = 0;
        ferr_exp++;
        run_frame(f, 20'($urandom), 20'($urandom));
    endtask

    task automatic gen_frame(output logic [255:0] f);
        logic [15:0] tag;
        logic [19:0] s1;
        logic [6:0]  a;
        int          kind;
        kind = $urandom_range(0, 3);
        a = ($urandom_range(0, 7) == 0) ? 7'h7C : 7'($urandom_range(0, 63) * 2);
        if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
        tag = 16'($urandom);
        s1 = 20'($urandom);
        if (kind == 1) begin
            tag = {3'b111, 2'($urandom), 11'($urandom)};
            s1 = {1'b0, a, 12'($urandom)};
        end else if (kind == 2) begin
            tag = {2'b11, 3'($urandom), 11'($urandom)};
            s1 = {1'b1, a, 12'($urandom)};
        end else if (kind == 3) begin
            tag = {1'b1, 2'($urandom), 2'b11, 11'($urandom)};
        end
        f = {tag, s1, 20'($urandom), 20'($urandom), 20'($urandom),
             32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    task automatic wait_rise(output int n);
        logic p;
        p = BIT_CLK;
        for (n = 1; n <= 100; n++) begin
            @(posedge clk_i);
            #1;
            if (BIT_CLK && !p) break;
            p = BIT_CLK;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [255:0] f, cap;
        int n;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_bit_clk", 64'(BIT_CLK), 64'd0);
        check("rst_sdata_in", 64'(SDATA_IN), 64'd0);
        check("rst_codec_ready", 64'(codec_ready), 64'd0);
        check("rst_strobes", 64'({pcm_valid, reg_wr, frame_err}), 64'd0);
        check("rst_pcm", 64'({pcm_left, pcm_right}), 64'd0);
        check("rst_wr_bus", 64'({reg_wr_addr, reg_wr_data}), 64'd0);
        RESET = 1'b0;
        wait_rise(n);
        check("first_rise_delay", 64'(n), 64'd4);
        wait_rise(n);
        check("bit_clk_period", 64'(n), 64'd8);

        for (int i = 0; i < 4; i++) run_frame(mk(16'h0000, 0, 0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'hE000, 20'h02000, 20'h12340, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'hE000, 20'h7C000, 20'hFFFF0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'hC000, 20'h82000, 0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'hC000, 20'hFC000, 0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'hC000, 20'hA6000, 0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'h9800, 0, 0, 20'hABCDE, 20'h12345), 20'h11111, 20'($urandom));
        run_frame(mk(16'h0000, 0, 0, 0, 0), 20'h11111, 20'($urandom));
        misalign_frame(mk(16'hF800, 20'h04000, 20'hAAAA0, 20'h55555, 20'h0F0F0),
                       mk(16'hE000, 20'h06000, 20'h77770, 0, 0));

        for (int i = 0; i < 8; i++) begin
            gen_frame(f);
            run_frame(f, 20'($urandom), 20'($urandom));
        end

        send_bits(mk(16'hE000, 20'h02000, 20'hBEEF0, 0, 0), 60, cap);
        RESET = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("midrst_codec_ready", 64'(codec_ready), 64'd0);
        check("midrst_sdata_in", 64'(SDATA_IN), 64'd0);
        check("midrst_bit_clk", 64'(BIT_CLK), 64'd0);
        RESET = 1'b0;
        model_reset();
        have_prev = 0;
        for (int i = 0; i < 4; i++) run_frame(mk(16'h0000, 0, 0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'hC000, 20'h82000, 0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'hC000, 20'h80000, 0, 0, 0), 20'($urandom), 20'($urandom));
        run_frame(mk(16'h0000, 0, 0, 0, 0), 20'($urandom), 20'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
